wb_arbiter: RTL and testbench

Single-port writeback arbiter for the general-purpose register file. It merges single-cycle ALU results with long-latency multiply/divide results into the one write port (`we`/`wa`/`wd`) that the register file exposes. It also keeps a busy scoreboard of destination registers owed by in-flight long-latency operations, so decode can stall on RAW/WAW hazards. It sits between the execute stage and the register file, on the writer side of the register-file write interface.

---
 rtl/wb_arbiter_pkg.sv | 11 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-pipeline definitions: register and data widths and the
// {address, data} request carried through the long-latency result queue.
package wb_arbiter_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of writeback requests. The pointers carry one
// extra wrap bit, so full and empty are told apart without a separate flag.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  din,
    input  logic                     pop,
    output wb_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer and count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued
// long-latency results onto the single register-file write port, and keeps
// the busy scoreboard of registers owed by in-flight long-latency ops.
// Handshake: an MDU result transfers on a rising edge where mdu_valid and
// mdu_ready are both high; mdu_ready depends only on registered queue state
// and rst, never on mdu_valid. The ALU side has no backpressure.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_wa,
    input  logic [31:0]              alu_wd,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_wa,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_wa,
    input  logic [31:0]              mdu_wd,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     rs_busy,
    output logic                     rt_busy,
    output logic                     we,
    output logic [4:0]               wa,
    output logic [31:0]              wd,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     waw_err
);
    wb_req_t      din;
    wb_req_t      head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         sel_valid;
    logic [4:0]   sel_wa;
    logic [31:0]  sel_wd;
    logic         sel_we;
    logic [31:0]  busy;
    logic [31:0]  busy_next;

    // A full queue refuses a push even in a cycle where it also pops.
    assign mdu_ready = !full && !rst;
    assign push      = mdu_valid && mdu_ready;
    assign pop       = !empty && !alu_valid;
    assign din.wa    = mdu_wa;
    assign din.wd    = mdu_wd;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Priority select: ALU first, then queue head.
    always_comb begin
        sel_valid = 1'b0;
        sel_wa    = alu_wa;
        sel_wd    = alu_wd;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_wa    = head.wa;
            sel_wd    = head.wd;
        end
    end

    // Writes to r0 are dropped; the popped entry is still consumed.
    assign sel_we = sel_valid && (sel_wa != 5'd0);

    // Registered write port; address and data hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= sel_we;
            if (sel_we) begin
                wa <= sel_wa;
                wd <= sel_wd;
            end
        end
    end

    // Scoreboard update: clear on pop, then set on issue so set wins.
    always_comb begin
        busy_next = busy;
        if (pop)         busy_next[head.wa]  = 1'b0;
        if (issue_valid) busy_next[issue_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    assign rs_busy = busy[rs];
    assign rt_busy = busy[rt];

    // Sticky flag for an ALU write landing on a register still owed by the MDU.
    always_ff @(posedge clk) begin
        if (rst) begin
            waw_err <= 1'b0;
        end else if (alu_valid && (alu_wa != 5'd0) && busy[alu_wa]) begin
            waw_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run, all judged
// against a queue-and-bitmask model of the writeback rules.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int OW = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [4:0]    alu_wa;
  logic [31:0]   alu_wd;
  logic          issue_valid;
  logic [4:0]    issue_wa;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_wa;
  logic [31:0]   mdu_wd;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          rs_busy;
  logic          rt_busy;
  logic          we;
  logic [4:0]    wa;
  logic [31:0]   wd;
  logic [OW-1:0] occupancy;
  logic          waw_err;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_wa      (mdu_wa),
    .mdu_wd      (mdu_wd),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .occupancy   (occupancy),
    .waw_err     (waw_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [36:0] exp_q[$];   // {wa, wd} in arrival order
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_err;

  // ---------------- driver tasks ----------------
  task automatic idle();
    alu_valid = 0; alu_wa = 0; alu_wd = 0;
    issue_valid = 0; issue_wa = 0;
    mdu_valid = 0; mdu_wa = 0; mdu_wd = 0;
    rs = 0; rt = 0;
  endtask

  // Advance one clock; the model applies the same inputs the DUT samples.
  task automatic tick();
    bit          ready;
    bit          do_pop;
    logic [36:0] h;
    ready  = !rst && (exp_q.size() < DEPTH);
    do_pop = (exp_q.size() > 0) && !alu_valid;
    if (rst) begin
      exp_q.delete();
      m_busy = 0; m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
    end else begin
      if (alu_valid) begin
        if (alu_wa != 0 && m_busy[alu_wa]) m_err = 1;
        m_we = (alu_wa != 0);
        if (alu_wa != 0) begin m_wa = alu_wa; m_wd = alu_wd; end
      end else if (do_pop) begin
        h = exp_q.pop_front();
        m_we = (h[36:32] != 0);
        if (h[36:32] != 0) begin m_wa = h[36:32]; m_wd = h[31:0]; end
        m_busy[h[36:32]] = 0;
      end else begin
        m_we = 0;
      end
      if (issue_valid) m_busy[issue_wa] = 1;
      m_busy[0] = 0;
      if (mdu_valid && ready) exp_q.push_back({mdu_wa, mdu_wd});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    issue_valid = 1; issue_wa = 8; tick();
    issue_wa = 9; tick();
    issue_valid = 0;
    alu_valid = 1; alu_wa = 1;
    mdu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mdu_wa = (i == 1) ? 5'd9 : 5'd8; mdu_wd = $urandom; alu_wd = $urandom;
      tick();
    end
    n_vec++; if (occupancy !== 3) begin n_err++; $display("FAIL reset_pre_occ: got %0d expected 3", occupancy); end
    idle(); rst = 1; rs = 8; tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", we); end
    n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    n_vec++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_r8: got %b expected 0", rs_busy); end
    n_vec++; if (waw_err !== 1'b0) begin n_err++; $display("FAIL reset_waw: got %b expected 0", waw_err); end
    n_vec++; if (wa !== 0 || wd !== 0) begin n_err++; $display("FAIL reset_wa_wd: got %0h/%0h expected 0/0", wa, wd); end
    n_vec++; if (mdu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst: got %b expected 0", mdu_ready); end
    rst = 0; #1;
    n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b expected 1", mdu_ready); end
  endtask

  task automatic test_alu();
    idle();
    alu_valid = 1; alu_wa = 5; alu_wd = 32'hDEADBEEF; tick();
    n_vec++; if (we !== 1'b1 || wa !== 5 || wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_write: got %b/%0d/%h expected 1/5/deadbeef", we, wa, wd); end
    alu_wa = 0; alu_wd = 32'h11111111; tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL alu_r0_we: got %b expected 0", we); end
    n_vec++; if (wa !== 5 || wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_r0_hold: got %0d/%h expected 5/deadbeef", wa, wd); end
    idle(); tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL alu_idle_we: got %b expected 0", we); end
  endtask

  task automatic test_round_trip();
    idle();
    issue_valid = 1; issue_wa = 12; tick();
    issue_valid = 0; rs = 12; rt = 12; #1;
    n_vec++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin n_err++; $display("FAIL rt_busy_set: got %b%b expected 11", rs_busy, rt_busy); end
    mdu_valid = 1; mdu_wa = 12; mdu_wd = 32'h1234; tick();
    mdu_valid = 0;
    n_vec++; if (we !== 1'b0 || occupancy !== 1 || rs_busy !== 1'b1) begin n_err++; $display("FAIL rt_after_push: got we=%b occ=%0d busy=%b expected 0/1/1", we, occupancy, rs_busy); end
    tick();
    n_vec++; if (we !== 1'b1 || wa !== 12 || wd !== 32'h1234) begin n_err++; $display("FAIL rt_write: got %b/%0d/%h expected 1/12/1234", we, wa, wd); end
    n_vec++; if (rs_busy !== 1'b0 || occupancy !== 0) begin n_err++; $display("FAIL rt_clear: got busy=%b occ=%0d expected 0/0", rs_busy, occupancy); end
  endtask

  task automatic test_preempt_full();
    logic [4:0]  a_wa[6];
    logic [31:0] a_wd[6];
    logic [31:0] q_wd[4];
    idle();
    for (int i = 0; i < 4; i++) q_wd[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      a_wa[i] = 5'($urandom_range(1, 31)); a_wd[i] = $urandom;
      alu_valid = 1; alu_wa = a_wa[i]; alu_wd = a_wd[i];
      mdu_valid = 1; mdu_wa = (i < 4) ? 5'(16 + i) : 5'd30; mdu_wd = (i < 4) ? q_wd[i] : 32'hBAD0BAD0;
      tick();
      n_vec++; if (we !== 1'b1 || wa !== a_wa[i] || wd !== a_wd[i]) begin n_err++; $display("FAIL pre_alu_%0d: got %b/%0d/%h expected 1/%0d/%h", i, we, wa, wd, a_wa[i], a_wd[i]); end
      if (i >= 3) begin
        n_vec++; if (occupancy !== 4 || mdu_ready !== 1'b0) begin n_err++; $display("FAIL pre_full_%0d: got occ=%0d rdy=%b expected 4/0", i, occupancy, mdu_ready); end
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (we !== 1'b1 || wa !== 5'(16 + i) || wd !== q_wd[i] || occupancy !== OW'(3 - i)) begin n_err++; $display("FAIL pre_drain_%0d: got %b/%0d/%h occ=%0d expected 1/%0d/%h occ=%0d", i, we, wa, wd, occupancy, 16 + i, q_wd[i], 3 - i); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [4:0] order[5];
    idle();
    alu_valid = 1; alu_wa = 2; mdu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mdu_wa = 5'(24 + i); mdu_wd = 32'hC000 + i; alu_wd = i; tick();
    end
    n_vec++; if (occupancy !== 4 || mdu_ready !== 1'b0) begin n_err++; $display("FAIL fpp_full: got occ=%0d rdy=%b expected 4/0", occupancy, mdu_ready); end
    alu_valid = 0; mdu_wa = 20; mdu_wd = 32'hC020; tick();
    n_vec++; if (occupancy !== 3 || mdu_ready !== 1'b1) begin n_err++; $display("FAIL fpp_pop_only: got occ=%0d rdy=%b expected 3/1", occupancy, mdu_ready); end
    tick();
    mdu_valid = 0;
    n_vec++; if (occupancy !== 3) begin n_err++; $display("FAIL fpp_push_pop: got occ=%0d expected 3", occupancy); end
    order[0] = 24; order[1] = 25; order[2] = 26; order[3] = 27; order[4] = 20;
    n_vec++; if (wa !== order[1]) begin n_err++; $display("FAIL fpp_order_1: got %0d expected %0d", wa, order[1]); end
    for (int i = 2; i < 5; i++) begin
      tick();
      n_vec++; if (we !== 1'b1 || wa !== order[i]) begin n_err++; $display("FAIL fpp_order_%0d: got %b/%0d expected 1/%0d", i, we, wa, order[i]); end
    end
  endtask

  task automatic test_waw();
    idle();
    issue_valid = 1; issue_wa = 7; tick();
    issue_valid = 0;
    n_vec++; if (waw_err !== 1'b0) begin n_err++; $display("FAIL waw_pre: got %b expected 0", waw_err); end
    alu_valid = 1; alu_wa = 7; alu_wd = 32'h77; tick();
    alu_valid = 0;
    n_vec++; if (we !== 1'b1 || wa !== 7 || wd !== 32'h77 || waw_err !== 1'b1) begin n_err++; $display("FAIL waw_latch: got %b/%0d/%h err=%b expected 1/7/77 err=1", we, wa, wd, waw_err); end
    tick();
    n_vec++; if (waw_err !== 1'b1) begin n_err++; $display("FAIL waw_sticky: got %b expected 1", waw_err); end
    issue_valid = 1; issue_wa = 9; tick();
    issue_valid = 0;
    mdu_valid = 1; mdu_wa = 9; mdu_wd = 32'h99; tick();
    mdu_valid = 0;
    issue_valid = 1; issue_wa = 9; tick();
    issue_valid = 0; rs = 9; #1;
    n_vec++; if (we !== 1'b1 || wa !== 9 || rs_busy !== 1'b1) begin n_err++; $display("FAIL waw_set_wins: got we=%b wa=%0d busy=%b expected 1/9/1", we, wa, rs_busy); end
  endtask

  task automatic test_random();
    idle(); rst = 1; tick(); rst = 0;
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) < 2);
      alu_valid   = ($urandom_range(0, 99) < 35);
      alu_wa      = 5'($urandom_range(0, 31)); alu_wd = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_wa    = 5'($urandom_range(0, 31));
      mdu_valid   = ($urandom_range(0, 99) < 50);
      mdu_wa      = 5'($urandom_range(0, 31)); mdu_wd = $urandom;
      rs          = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      #1;
      n_vec++; if (mdu_ready !== (!rst && exp_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b", c, mdu_ready); end
      n_vec++; if (rs_busy !== m_busy[rs] || rt_busy !== m_busy[rt]) begin n_err++; $display("FAIL rnd_busy c%0d: got %b%b expected %b%b", c, rs_busy, rt_busy, m_busy[rs], m_busy[rt]); end
      tick();
      n_vec++; if (we !== m_we || wa !== m_wa || wd !== m_wd) begin n_err++; $display("FAIL rnd_port c%0d: got %b/%0d/%h expected %b/%0d/%h", c, we, wa, wd, m_we, m_wa, m_wd); end
      n_vec++; if (occupancy !== OW'(exp_q.size()) || waw_err !== m_err) begin n_err++; $display("FAIL rnd_state c%0d: got occ=%0d err=%b expected %0d/%b", c, occupancy, waw_err, exp_q.size(), m_err); end
    end
    rst = 0; idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    test_reset();
    test_alu();
    test_round_trip();
    test_preempt_full();
    test_full_push_pop();
    test_waw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
